// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer and its interval timer.
package traffic_pkg;

    localparam int TMR_NBITS = 32;

    typedef enum logic [2:0] {
        RED2     = 3'd0,
        NS_GRN   = 3'd1,
        NS_YEL   = 3'd2,
        RED1     = 3'd3,
        EW_GRN   = 3'd4,
        EW_YEL   = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    // One-hot {R,Y,G} lamp drive.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_light_ctrl_req_latch.sv
// Request flop: set by a level request, cleared on entry to the serving phase,
// and deaf during that phase's first cycle so a request then is absorbed.
module req_latch (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic enter,
    input  logic absorb,
    output logic pend
);

    always_ff @(posedge clk) begin
        if (!reset)
            pend <= 1'b0;
        else if (enter)
            pend <= 1'b0;
        else if (!absorb)
            pend <= pend | req;
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: NS main road, EW side road, pedestrian walk; drives one
// interval timer (clear + limit) per phase and advances on its expiry pulse.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int          NBITS      = TMR_NBITS,
    parameter int unsigned NS_MIN_CYC = 40,
    parameter int unsigned EW_GRN_CYC = 20,
    parameter int unsigned YEL_CYC    = 6,
    parameter int unsigned RED_CYC    = 3,
    parameter int unsigned WALK_CYC   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ew_car,
    input  logic             ped_req,
    input  logic             tmr_done,
    output logic             tmr_clr,
    output logic [NBITS-1:0] tmr_limit,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk
);

    state_t             state, state_nxt;
    logic               ew_pend, ped_pend, min_done;
    logic               done_ok;
    logic [2:0]         ns_nxt, ew_nxt;
    logic               walk_nxt;
    logic [NBITS-1:0]   limit_nxt;

    // tmr_clr is high exactly in a state's first cycle, where a pulse may be stale.
    assign done_ok = tmr_done & ~tmr_clr;

    req_latch u_ew_latch (
        .clk    (clk),
        .reset  (reset),
        .req    (ew_car),
        .enter  ((state_nxt == EW_GRN) && (state != EW_GRN)),
        .absorb (tmr_clr && (state == EW_GRN)),
        .pend   (ew_pend)
    );

    req_latch u_ped_latch (
        .clk    (clk),
        .reset  (reset),
        .req    (ped_req),
        .enter  ((state_nxt == PED_WALK) && (state != PED_WALK)),
        .absorb (tmr_clr && (state == PED_WALK)),
        .pend   (ped_pend)
    );

    always_comb begin
        state_nxt = state;
        ns_nxt    = LAMP_RED;
        ew_nxt    = LAMP_RED;
        walk_nxt  = 1'b0;
        limit_nxt = NBITS'(RED_CYC);
        case (state)
            RED2:     if (done_ok) state_nxt = ped_pend ? PED_WALK : NS_GRN;
            // The expiry edge itself already counts as the minimum having elapsed.
            NS_GRN:   if ((min_done || done_ok) && (ew_pend || ped_pend)) state_nxt = NS_YEL;
            NS_YEL:   if (done_ok) state_nxt = RED1;
            RED1:     if (done_ok) state_nxt = ew_pend ? EW_GRN : PED_WALK;
            EW_GRN:   if (done_ok) state_nxt = EW_YEL;
            EW_YEL:   if (done_ok) state_nxt = RED2;
            PED_WALK: if (done_ok) state_nxt = NS_GRN;
            default:  state_nxt = RED2;
        endcase
        case (state_nxt)
            NS_GRN:   begin ns_nxt = LAMP_GRN; limit_nxt = NBITS'(NS_MIN_CYC); end
            NS_YEL:   begin ns_nxt = LAMP_YEL; limit_nxt = NBITS'(YEL_CYC);    end
            EW_GRN:   begin ew_nxt = LAMP_GRN; limit_nxt = NBITS'(EW_GRN_CYC); end
            EW_YEL:   begin ew_nxt = LAMP_YEL; limit_nxt = NBITS'(YEL_CYC);    end
            PED_WALK: begin walk_nxt = 1'b1;   limit_nxt = NBITS'(WALK_CYC);   end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RED2;
            tmr_clr   <= 1'b1;
            tmr_limit <= NBITS'(RED_CYC);
            ns_light  <= LAMP_RED;
            ew_light  <= LAMP_RED;
            walk      <= 1'b0;
            min_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr_clr   <= (state_nxt != state);
            tmr_limit <= limit_nxt;
            ns_light  <= ns_nxt;
            ew_light  <= ew_nxt;
            walk      <= walk_nxt;
            min_done  <= (state == NS_GRN) && (state_nxt == NS_GRN) && (min_done || done_ok);
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: phase/age model plus directed run-length checks.
module tb_traffic_light_ctrl;

    localparam int NS_MIN = 10, EWG = 8, YEL = 3, RED = 2, WLK = 6;
    localparam logic [6:0] C_RED  = {3'b100, 3'b100, 1'b0};
    localparam logic [6:0] C_NSG  = {3'b001, 3'b100, 1'b0};
    localparam logic [6:0] C_NSY  = {3'b010, 3'b100, 1'b0};
    localparam logic [6:0] C_EWG  = {3'b100, 3'b001, 1'b0};
    localparam logic [6:0] C_EWY  = {3'b100, 3'b010, 1'b0};
    localparam logic [6:0] C_WALK = {3'b100, 3'b100, 1'b1};

    logic       clk = 1'b0;
    logic       reset, ew_car, ped_req, tmr_done, spur;
    logic       tmr_clr, walk;
    logic [7:0] tmr_limit, tcnt;
    logic [2:0] ns_light, ew_light;
    int         total = 0, bad = 0;

    traffic_light_ctrl #(
        .NBITS(8), .NS_MIN_CYC(NS_MIN), .EW_GRN_CYC(EWG),
        .YEL_CYC(YEL), .RED_CYC(RED), .WALK_CYC(WLK)
    ) dut (
        .clk(clk), .reset(reset), .ew_car(ew_car), .ped_req(ped_req),
        .tmr_done(tmr_done), .tmr_clr(tmr_clr), .tmr_limit(tmr_limit),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk)
    );

    always #5 clk = ~clk;

    // Interval timer: clears on the clr edge, counts once per cycle, pulses at limit.
    always @(posedge clk) begin
        if (tmr_clr) tcnt <= 8'd0;
        else if (tcnt <= tmr_limit) tcnt <= tcnt + 8'd1;
    end
    assign tmr_done = (!tmr_clr && tcnt == tmr_limit) || spur;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each phase is a name plus its age in cycles; timed phases last limit+2.
    localparam int P_R2 = 0, P_NG = 1, P_NY = 2, P_R1 = 3, P_EG = 4, P_EY = 5, P_PW = 6;
    int m_ph = P_R2, m_age = 0;
    bit m_ew = 0, m_ped = 0, m_valid = 0;

    function automatic int lim_of(input int ph);
        case (ph)
            P_NG:       return NS_MIN;
            P_NY, P_EY: return YEL;
            P_EG:       return EWG;
            P_PW:       return WLK;
            default:    return RED;
        endcase
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit last;
        if (!reset) begin
            m_ph = P_R2; m_age = 0; m_ew = 0; m_ped = 0; m_valid = 1;
        end else if (m_valid) begin
            last = (m_age == lim_of(m_ph) + 1);
            nxt  = m_ph;
            case (m_ph)
                P_R2: if (last) nxt = m_ped ? P_PW : P_NG;
                P_NG: if (m_age >= NS_MIN + 1 && (m_ew || m_ped)) nxt = P_NY;
                P_NY: if (last) nxt = P_R1;
                P_R1: if (last) nxt = m_ew ? P_EG : P_PW;
                P_EG: if (last) nxt = P_EY;
                P_EY: if (last) nxt = P_R2;
                default: if (last) nxt = P_NG;
            endcase
            if (nxt == P_EG && m_ph != P_EG) m_ew = 0;
            else if (!(m_ph == P_EG && m_age == 0)) m_ew = m_ew | ew_car;
            if (nxt == P_PW && m_ph != P_PW) m_ped = 0;
            else if (!(m_ph == P_PW && m_age == 0)) m_ped = m_ped | ped_req;
            m_age = (nxt != m_ph) ? 0 : m_age + 1;
            m_ph  = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_clr",   int'(tmr_clr),   int'(m_age == 0));
            chk("m_limit", int'(tmr_limit), lim_of(m_ph));
            chk("m_ns",    int'(ns_light),  m_ph == P_NG ? 1 : m_ph == P_NY ? 2 : 4);
            chk("m_ew",    int'(ew_light),  m_ph == P_EG ? 1 : m_ph == P_EY ? 2 : 4);
            chk("m_walk",  int'(walk),      int'(m_ph == P_PW));
            chk("safety",  int'((ns_light != 3'b100 && ew_light != 3'b100) ||
                                (walk && (ns_light != 3'b100 || ew_light != 3'b100))), 0);
        end
    end

    function automatic logic [6:0] cur();
        return {ns_light, ew_light, walk};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_len(input logic [6:0] code, output int n);
        n = 0;
        while (cur() == code && n < 300) begin n++; @(negedge clk); end
    endtask

    task automatic wait_code(input logic [6:0] code, input int lim);
        int k = 0;
        while (cur() != code && k < lim) begin k++; @(negedge clk); end
        chk("wait_reach", int'(cur()), int'(code));
    endtask

    initial begin
        int n, cnt;
        reset = 1'b0; ew_car = 1'b0; ped_req = 1'b0; spur = 1'b0;
        cyc(2);
        chk("rst_clr", int'(tmr_clr), 1);
        chk("rst_lamps", int'(cur()), int'(C_RED));
        chk("rst_limit", int'(tmr_limit), RED);
        cyc(1);
        reset = 1'b1;

        // Quiet start: RED2 4 cycles then NS green forever with a single clr.
        run_len(C_RED, n);           chk("red2_len", n, 4);
        chk("ng_clr", int'(tmr_clr), 1);
        chk("ng_limit", int'(tmr_limit), NS_MIN);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            cnt += int'(tmr_clr) + int'(cur() != C_NSG);
        end
        chk("ng_hold", cnt, 0);

        // Late request after the minimum has elapsed.
        ew_car = 1'b1; cyc(1); ew_car = 1'b0;
        chk("late_still_g", int'(ns_light), 1);
        cyc(1);
        chk("late_yel", int'(ns_light), 2);
        wait_code(C_NSG, 60);

        // EW request three cycles into a fresh NS green.
        cyc(3); ew_car = 1'b1; cyc(1); ew_car = 1'b0;
        run_len(C_NSG, n);           chk("ew_ng_len", n + 4, 12);
        run_len(C_NSY, n);           chk("ew_ny_len", n, 5);
        run_len(C_RED, n);           chk("ew_r1_len", n, 4);
        chk("eg_limit", int'(tmr_limit), EWG);
        run_len(C_EWG, n);           chk("ew_eg_len", n, 10);
        run_len(C_EWY, n);           chk("ew_ey_len", n, 5);
        run_len(C_RED, n);           chk("ew_r2_len", n, 4);

        // Pedestrian only.
        cyc(2); ped_req = 1'b1; cyc(1); ped_req = 1'b0;
        run_len(C_NSG, n);           chk("pd_ng_len", n + 3, 12);
        run_len(C_NSY, n);           chk("pd_ny_len", n, 5);
        run_len(C_RED, n);           chk("pd_r1_len", n, 4);
        chk("pw_limit", int'(tmr_limit), WLK);
        chk("pw_clr", int'(tmr_clr), 1);
        run_len(C_WALK, n);          chk("pw_len", n, 8);
        chk("pd_back_ng", int'(cur()), int'(C_NSG));

        // Both requests: EW first, then walk; a request in the walk entry cycle is absorbed.
        cyc(1); ew_car = 1'b1; ped_req = 1'b1; cyc(1); ew_car = 1'b0; ped_req = 1'b0;
        run_len(C_NSG, n);           chk("bo_ng_len", n + 2, 12);
        run_len(C_NSY, n);           chk("bo_ny_len", n, 5);
        run_len(C_RED, n);           chk("bo_r1_len", n, 4);
        chk("bo_ew_first", int'(cur()), int'(C_EWG));
        run_len(C_EWG, n);           chk("bo_eg_len", n, 10);
        run_len(C_EWY, n);           chk("bo_ey_len", n, 5);
        run_len(C_RED, n);           chk("bo_r2_len", n, 4);
        chk("bo_walk", int'(walk), 1);
        ped_req = 1'b1; cyc(1); ped_req = 1'b0;
        run_len(C_WALK, n);          chk("bo_pw_len", n + 1, 8);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            cnt += int'(cur() != C_NSG);
        end
        chk("no_second_walk", cnt, 0);

        // Spurious pulses: after min_done in NS green, then in first cycles.
        spur = 1'b1; cyc(1); spur = 1'b0;
        chk("spur_ng", int'(ns_light), 1);
        ew_car = 1'b1; cyc(1); ew_car = 1'b0; cyc(1);
        chk("rb_ny", int'(ns_light), 2);
        spur = 1'b1; cyc(1); spur = 1'b0;
        run_len(C_NSY, n);           chk("rb_ny_len", n + 1, 5);
        spur = 1'b1; cyc(1); spur = 1'b0;
        run_len(C_RED, n);           chk("rb_r1_len", n + 1, 4);
        chk("rb_eg", int'(cur()), int'(C_EWG));
        spur = 1'b1; cyc(1); spur = 1'b0;
        cyc(3);
        chk("rb_eg_mid", int'(cur()), int'(C_EWG));
        reset = 1'b0; cyc(1);
        chk("mid_rst_lamps", int'(cur()), int'(C_RED));
        chk("mid_rst_clr", int'(tmr_clr), 1);
        chk("mid_rst_limit", int'(tmr_limit), RED);
        reset = 1'b1;
        run_len(C_RED, n);           chk("mid_rst_r2_len", n, 4);
        chk("mid_rst_ng", int'(cur()), int'(C_NSG));
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Intersection sequencer driving North-South (main) and East-West (side) signal heads plus a pedestrian WALK lamp.
- Initiator side of the interval-timer interface: per phase it loads an interval (tmr_limit), clears the timer (tmr_clr) and waits for the single-cycle expiry pulse (tmr_done).
- Sits between sensor synchronisers and lamp drivers; one instance per intersection, paired with one interval timer.

Parameters:
- NBITS, 32, width of tmr_limit; must match the paired timer.
- NS_MIN_CYC, 40, minimum NS green interval (timer limit).
- EW_GRN_CYC, 20, fixed EW green interval.
- YEL_CYC, 6, yellow interval, both directions.
- RED_CYC, 3, all-red clearance interval.
- WALK_CYC, 15, pedestrian walk interval.
- All interval parameters must be >= 1 and < 2**NBITS.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low.
- ew_car, input, 1, side-road vehicle present (pre-synchronised), level.
- ped_req, input, 1, pedestrian button (pre-synchronised), sampled every cycle.
- tmr_done, input, 1, timer expiry pulse, one cycle wide.
- tmr_clr, output, 1, active-high timer clear; registered.
- tmr_limit, output, NBITS, interval for the current phase; registered, stable for the whole phase.
- ns_light, output, 3, one-hot {R,Y,G}: 100 red, 010 yellow, 001 green.
- ew_light, output, 3, same encoding.
- walk, output, 1, pedestrian WALK lamp.

Behaviour:
- States: RED2 (reset state), NS_GRN, NS_YEL, RED1, EW_GRN, EW_YEL, PED_WALK. All outputs registered and decoded from the next state, so lamps change on the same edge the state changes.
- While reset=0 at a clock edge:
  - state=RED2.
  - ns_light=ew_light=100, walk=0.
  - tmr_clr=1, tmr_limit=RED_CYC.
  - ew_pend=0, ped_pend=0, min_done=0.
- Phase entry rules:
  - tmr_clr=1 for exactly the first cycle of every state; 0 otherwise.
  - tmr_limit takes the new phase interval on the entry edge.
  - tmr_done is ignored in the first cycle of a state, which masks stale pulses.
- Timer contract: the timer clears on the edge ending the clr cycle and counts one per cycle. Every timed phase therefore dwells exactly limit+2 cycles. The controller moves on the edge at which it samples tmr_done=1.
- Request latches:
  - ew_pend is set by ew_car=1 and cleared on entry to EW_GRN.
  - ped_pend is set by ped_req=1 and cleared on entry to PED_WALK. A request in the entry cycle is absorbed, not re-latched.
- Transitions:
  - RED2 --done--> PED_WALK if ped_pend, else NS_GRN.
  - NS_GRN: done sets min_done. Once min_done=1 and (ew_pend or ped_pend), go to NS_YEL on the next edge. With no request, NS stays green indefinitely (no re-clear). min_done is cleared on leaving NS_GRN.
  - NS_YEL --done--> RED1.
  - RED1 --done--> EW_GRN if ew_pend, else PED_WALK.
  - EW_GRN --done--> EW_YEL --done--> RED2.
  - PED_WALK --done--> NS_GRN.
- Lamps per state:
  - NS_GRN: ns=001, ew=100.
  - NS_YEL: ns=010, ew=100.
  - EW_GRN: ns=100, ew=001.
  - EW_YEL: ns=100, ew=010.
  - RED1, RED2: both 100, walk=0.
  - PED_WALK: both 100, walk=1.
- Safety invariant: never both directions non-red; walk=1 only with both heads red.
- Unexpected tmr_done (e.g. a spurious second pulse) only acts where a done is awaited. In NS_GRN after min_done it has no effect.
- Illegal state encoding recovers to RED2 with tmr_clr=1.
- Reset mid-phase: all outputs go to reset values on the next edge, regardless of state or pending requests.

Decomposition:
- Shared package traffic_pkg:
  - state enum.
  - lamp constants LAMP_RED/LAMP_YEL/LAMP_GRN.
  - interval-timer interface width default.
- One natural sub-module: req_latch (set/clear-on-entry request flop with absorb rule), instanced for ew_pend and ped_pend.

Test Plan:
- Common setup: NBITS=8, NS_MIN=10, EW_GRN=8, YEL=3, RED=2, WALK=6, behavioural timer model.
- Reset and quiet start: hold reset=0 for 3 cycles, then release with no requests -> both heads 100, tmr_clr=1 during reset; RED2 dwells 4 cycles; NS_GRN (001) with tmr_limit=10 held forever; tmr_clr pulses exactly once on entry.
- EW request: ew_car=1 for 1 cycle, 3 cycles into NS_GRN -> NS green total 12 cycles, then NS_YEL 5, RED1 4, EW_GRN 10, EW_YEL 5, RED2 4, then NS_GRN; ew_pend clears on EW_GRN entry.
- Late request: ew_car asserted after min_done -> NS_YEL entered exactly 1 cycle later.
- Pedestrian only: ped_req pulse during NS_GRN -> NS_YEL, RED1, then PED_WALK (walk=1, both red, tmr_limit=6) for 8 cycles, then NS_GRN.
- Both requests: ew_car and ped_req together -> EW phase first, RED2, then PED_WALK; a ped_req pulse in the PED_WALK entry cycle is absorbed with no second walk.
- Robustness: inject a spurious tmr_done in first-cycle positions and toggle reset=0 mid-EW_GRN -> the first-cycle pulse is ignored; reset returns to RED2 values on the next edge; the safety invariant assertion holds throughout.
